// File: rtl/trap_report_arbiter.sv
// trap_report_arbiter
//
// Collects good/bad trap events from up to 8 harts and serialises them onto
// the single simulation-monitor trap-report port. It also keeps the global
// cycle counter and the per-hart committed-instruction counters, and runs a
// no-commit watchdog. The end of simulation is sequenced here too.
//
// State table:
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_RUN    | counting; arbitrating trap requests; watchdog armed
//   S_REPORT | one-cycle mon_valid pulse carrying the captured report
//   S_DONE   | simulation finished; counters frozen until reset
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   trap_valid      per-hart trap request, held until accepted
//   trap_code       per-hart 32-bit trap code (0 = good trap)
//   trap_pc         per-hart 64-bit trap PC
//   commit_cnt      per-hart 2-bit commit count for this cycle
//   trap_ready      one-hot accept toward the granted hart
//   mon_valid       one-cycle pulse, report fields valid
//   mon_hart        reporting hart (4'hF = watchdog)
//   mon_code/pc     captured trap code and PC
//   mon_cycle       cycle counter value at capture
//   mon_instr       reporting hart's instruction count at capture
//   done            simulation finished, sticky until reset
module trap_report_arbiter #(
    parameter int unsigned NUM_HARTS     = 2,
    parameter int unsigned TIMEOUT       = 5000,
    parameter bit          ABORT_ON_FAIL = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_HARTS-1:0]      trap_valid,
    input  logic [32*NUM_HARTS-1:0]   trap_code,
    input  logic [64*NUM_HARTS-1:0]   trap_pc,
    input  logic [2*NUM_HARTS-1:0]    commit_cnt,
    output logic [NUM_HARTS-1:0]      trap_ready,
    output logic                      mon_valid,
    output logic [3:0]                mon_hart,
    output logic [31:0]               mon_code,
    output logic [63:0]               mon_pc,
    output logic [63:0]               mon_cycle,
    output logic [63:0]               mon_instr,
    output logic                      done
);

    localparam int unsigned PTR_W    = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
    localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_REPORT = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [63:0]          cycle_q, cycle_d;
    logic [63:0]          instr_q [NUM_HARTS];
    logic [63:0]          instr_d [NUM_HARTS];
    logic [NUM_HARTS-1:0] trapped_q, trapped_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [31:0]          wd_q, wd_d;
    logic                 exit_q, exit_d;
    logic [3:0]           cap_hart_q, cap_hart_d;
    logic [31:0]          cap_code_q, cap_code_d;
    logic [63:0]          cap_pc_q, cap_pc_d;
    logic [63:0]          cap_cycle_q, cap_cycle_d;
    logic [63:0]          cap_instr_q, cap_instr_d;

    logic [NUM_HARTS-1:0] eligible;
    logic                 grant_vld;
    logic [PTR_W-1:0]     grant_idx;
    logic                 handshake;

    assign eligible = trap_valid & ~trapped_q;

    // Round-robin search: first eligible hart at or after the pointer.
    always_comb begin
        int unsigned idx;
        logic [PTR_W-1:0] idx_w;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        idx_w     = '0;
        for (int k = 0; k < int'(NUM_HARTS); k++) begin
            idx = 32'(ptr_q) + 32'(k);
            if (idx >= NUM_HARTS) begin
                idx = idx - NUM_HARTS;
            end
            idx_w = PTR_W'(idx);
            if (!grant_vld && eligible[idx_w]) begin
                grant_vld = 1'b1;
                grant_idx = idx_w;
            end
        end
    end

    assign handshake = (state_q == S_RUN) && grant_vld && !reset;

    always_comb begin
        trap_ready = '0;
        if (handshake) begin
            trap_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cycle_d     = cycle_q;
        instr_d     = instr_q;
        trapped_d   = trapped_q;
        ptr_d       = ptr_q;
        wd_d        = wd_q;
        exit_d      = exit_q;
        cap_hart_d  = cap_hart_q;
        cap_code_d  = cap_code_q;
        cap_pc_d    = cap_pc_q;
        cap_cycle_d = cap_cycle_q;
        cap_instr_d = cap_instr_q;

        if (state_q != S_DONE) begin
            cycle_d = cycle_q + 64'd1;
            for (int i = 0; i < int'(NUM_HARTS); i++) begin
                if (!trapped_q[i]) begin
                    instr_d[i] = instr_q[i] + 64'(commit_cnt[2*i +: 2]);
                end
            end
            // wd_d counts the current cycle, so the watchdog fires in the
            // cycle where the idle run first reaches TIMEOUT.
            if (|commit_cnt) begin
                wd_d = '0;
            end else if (wd_q < WD_LIMIT) begin
                wd_d = wd_q + 32'd1;
            end
        end

        case (state_q)
            S_RUN: begin
                if (handshake) begin
                    cap_hart_d  = 4'(grant_idx);
                    cap_code_d  = trap_code[32*grant_idx +: 32];
                    cap_pc_d    = trap_pc[64*grant_idx +: 64];
                    cap_cycle_d = cycle_q;
                    // The granted hart is not yet trapped, so instr_d
                    // already includes its commits from this cycle.
                    cap_instr_d = instr_d[grant_idx];
                    trapped_d[grant_idx] = 1'b1;
                    if (32'(grant_idx) == NUM_HARTS - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = grant_idx + 1'b1;
                    end
                    exit_d  = 1'b0;
                    state_d = S_REPORT;
                end else if ((TIMEOUT != 0) && (wd_d == WD_LIMIT)) begin
                    cap_hart_d  = 4'hF;
                    cap_code_d  = 32'hFFFF_FFFE;
                    cap_pc_d    = '0;
                    cap_cycle_d = cycle_q;
                    cap_instr_d = '0;
                    exit_d      = 1'b1;
                    state_d     = S_REPORT;
                end
            end
            S_REPORT: begin
                if ((&trapped_q) || exit_q || (ABORT_ON_FAIL && (cap_code_q != '0))) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_RUN;
            cycle_q     <= '0;
            for (int i = 0; i < int'(NUM_HARTS); i++) begin
                instr_q[i] <= '0;
            end
            trapped_q   <= '0;
            ptr_q       <= '0;
            wd_q        <= '0;
            exit_q      <= 1'b0;
            cap_hart_q  <= '0;
            cap_code_q  <= '0;
            cap_pc_q    <= '0;
            cap_cycle_q <= '0;
            cap_instr_q <= '0;
        end else begin
            state_q     <= state_d;
            cycle_q     <= cycle_d;
            instr_q     <= instr_d;
            trapped_q   <= trapped_d;
            ptr_q       <= ptr_d;
            wd_q        <= wd_d;
            exit_q      <= exit_d;
            cap_hart_q  <= cap_hart_d;
            cap_code_q  <= cap_code_d;
            cap_pc_q    <= cap_pc_d;
            cap_cycle_q <= cap_cycle_d;
            cap_instr_q <= cap_instr_d;
        end
    end

    assign mon_valid = (state_q == S_REPORT);
    assign done      = (state_q == S_DONE);
    assign mon_hart  = cap_hart_q;
    assign mon_code  = cap_code_q;
    assign mon_pc    = cap_pc_q;
    assign mon_cycle = cap_cycle_q;
    assign mon_instr = cap_instr_q;

endmodule

// File: tb/tb_trap_report_arbiter.sv
// Testbench for trap_report_arbiter: 4 harts, TIMEOUT=8, ABORT_ON_FAIL=1.
// A cycle-level behavioural model is compared against the DUT on every
// negative clock edge; directed scenarios add hand-computed report checks.
module tb_trap_report_arbiter;

    localparam int N = 4;
    localparam int T = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      trap_valid;
    logic [32*N-1:0]   trap_code;
    logic [64*N-1:0]   trap_pc;
    logic [2*N-1:0]    commit_cnt;
    logic [N-1:0]      trap_ready;
    logic              mon_valid;
    logic [3:0]        mon_hart;
    logic [31:0]       mon_code;
    logic [63:0]       mon_pc;
    logic [63:0]       mon_cycle;
    logic [63:0]       mon_instr;
    logic              done;

    int errors = 0;
    int checks = 0;
    int tcyc   = 0;

    always #5 clk = ~clk;

    trap_report_arbiter #(
        .NUM_HARTS    (N),
        .TIMEOUT      (T),
        .ABORT_ON_FAIL(1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .trap_valid (trap_valid),
        .trap_code  (trap_code),
        .trap_pc    (trap_pc),
        .commit_cnt (commit_cnt),
        .trap_ready (trap_ready),
        .mon_valid  (mon_valid),
        .mon_hart   (mon_hart),
        .mon_code   (mon_code),
        .mon_pc     (mon_pc),
        .mon_cycle  (mon_cycle),
        .mon_instr  (mon_instr),
        .done       (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, tcyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint unsigned m_cycles;
    longint unsigned m_instr [N];
    bit              m_trapped [N];
    int              m_next;
    int              m_idle;
    bit              m_reporting;
    bit              m_finished;
    bit              m_wd_exit;
    logic [3:0]      e_hart;
    logic [31:0]     e_code;
    logic [63:0]     e_pc, e_cycle, e_instr;

    typedef struct {
        int          t;
        logic [3:0]  hart;
        logic [31:0] code;
        logic [63:0] pc;
        logic [63:0] cyc;
        logic [63:0] instr;
    } rep_t;
    rep_t log_q[$];

    always @(negedge clk) begin
        int         grant;
        int         h;
        logic [N-1:0] exp_ready;
        bit         all_trapped;
        rep_t       r;
        if (reset) begin
            check("ready_in_reset", 64'(trap_ready), 64'd0);
            m_cycles = 0; m_next = 0; m_idle = 0;
            m_reporting = 0; m_finished = 0; m_wd_exit = 0;
            for (int i = 0; i < N; i++) begin
                m_instr[i] = 0; m_trapped[i] = 0;
            end
            e_hart = 0; e_code = 0; e_pc = 0; e_cycle = 0; e_instr = 0;
        end else begin
            grant = -1;
            exp_ready = '0;
            if (!m_reporting && !m_finished) begin
                for (int k = 0; k < N; k++) begin
                    h = (m_next + k) % N;
                    if (grant < 0 && trap_valid[h] && !m_trapped[h]) grant = h;
                end
            end
            if (grant >= 0) exp_ready[grant] = 1'b1;
            check("trap_ready", 64'(trap_ready), 64'(exp_ready));
            check("mon_valid",  64'(mon_valid),  64'(m_reporting));
            check("done",       64'(done),       64'(m_finished));
            check("mon_hart",   64'(mon_hart),   64'(e_hart));
            check("mon_code",   64'(mon_code),   64'(e_code));
            check("mon_pc",     mon_pc,          e_pc);
            check("mon_cycle",  mon_cycle,       e_cycle);
            check("mon_instr",  mon_instr,       e_instr);
            if (mon_valid === 1'b1) begin
                r.t = tcyc; r.hart = mon_hart; r.code = mon_code;
                r.pc = mon_pc; r.cyc = mon_cycle; r.instr = mon_instr;
                log_q.push_back(r);
            end
            if (!m_finished) begin
                m_idle = (commit_cnt == '0) ? ((m_idle < T) ? m_idle + 1 : T) : 0;
                for (int i = 0; i < N; i++) begin
                    if (!m_trapped[i]) m_instr[i] += longint'(commit_cnt[2*i +: 2]);
                end
                if (m_reporting) begin
                    m_reporting = 0;
                    all_trapped = 1;
                    for (int i = 0; i < N; i++) if (!m_trapped[i]) all_trapped = 0;
                    if (all_trapped || m_wd_exit || e_code != 0) m_finished = 1;
                end else if (grant >= 0) begin
                    e_hart  = 4'(grant);
                    e_code  = trap_code[32*grant +: 32];
                    e_pc    = trap_pc[64*grant +: 64];
                    e_cycle = m_cycles;
                    e_instr = m_instr[grant];
                    m_trapped[grant] = 1;
                    m_next = (grant + 1) % N;
                    m_wd_exit = 0;
                    m_reporting = 1;
                end else if (T != 0 && m_idle == T) begin
                    e_hart = 4'hF; e_code = 32'hFFFF_FFFE; e_pc = 0;
                    e_cycle = m_cycles; e_instr = 0;
                    m_wd_exit = 1;
                    m_reporting = 1;
                end
                m_cycles++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // One clock: requests that were accepted this cycle are dropped.
    task automatic step();
        logic [N-1:0] hs;
        #2;
        hs = trap_valid & trap_ready;
        @(posedge clk);
        #1;
        trap_valid = trap_valid & ~hs;
        tcyc++;
    endtask

    task automatic run_until(input int n);
        while (tcyc < n) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        trap_valid = '0;
        step();
        step();
        reset = 1'b0;
        tcyc = 0;
        log_q.delete();
    endtask

    task automatic check_rep(input string name, input int i, input int t, input logic [3:0] hart,
                             input logic [31:0] code, input logic [63:0] pc,
                             input logic [63:0] cyc, input logic [63:0] instr);
        check({name, "_present"}, 64'(log_q.size() > i), 64'd1);
        if (log_q.size() > i) begin
            check({name, "_t"},     64'(log_q[i].t), 64'(t));
            check({name, "_hart"},  64'(log_q[i].hart), 64'(hart));
            check({name, "_code"},  64'(log_q[i].code), 64'(code));
            check({name, "_pc"},    log_q[i].pc, pc);
            check({name, "_cycle"}, log_q[i].cyc, cyc);
            check({name, "_instr"}, log_q[i].instr, instr);
        end
    endtask

    initial begin
        reset = 1'b1; trap_valid = '0; trap_code = '0; trap_pc = '0; commit_cnt = '0;

        // Single good trap on hart 0 at cycle 10.
        do_reset();
        #1;
        check("rst_mon_valid", 64'(mon_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_mon_cycle", mon_cycle, 64'd0);
        commit_cnt = 8'b01_01_01_01;
        run_until(10);
        trap_valid[0] = 1'b1; trap_code[31:0] = 32'd0; trap_pc[63:0] = 64'h8000_0100;
        #1;
        check("s1_ready_c10", 64'(trap_ready), 64'h1);
        run_until(12);
        #1;
        check("s1_done_c12", 64'(done), 64'd0);
        run_until(14);
        check("s1_reports", 64'(log_q.size()), 64'd1);
        check_rep("s1", 0, 11, 4'h0, 32'd0, 64'h8000_0100, 64'd10, 64'd11);

        // Round-robin: all four request together at cycle 5.
        do_reset();
        commit_cnt = 8'b01_01_01_01;
        run_until(5);
        for (int h = 0; h < N; h++) begin
            trap_code[32*h +: 32] = 32'd0;
            trap_pc[64*h +: 64]   = 64'h1000 + 64'(h * 4);
        end
        trap_valid = 4'hF;
        run_until(12);
        #1;
        check("s2_done_c12", 64'(done), 64'd0);
        run_until(13);
        #1;
        check("s2_done_c13", 64'(done), 64'd1);
        run_until(14);
        trap_valid[0] = 1'b1;
        run_until(17);
        check("s2_reports", 64'(log_q.size()), 64'd4);
        check_rep("s2_h0", 0, 6,  4'h0, 32'd0, 64'h1000, 64'd5,  64'd6);
        check_rep("s2_h1", 1, 8,  4'h1, 32'd0, 64'h1004, 64'd7,  64'd8);
        check_rep("s2_h2", 2, 10, 4'h2, 32'd0, 64'h1008, 64'd9,  64'd10);
        check_rep("s2_h3", 3, 12, 4'h3, 32'd0, 64'h100C, 64'd11, 64'd12);

        // Bad trap on hart 1 aborts; hart 0's later request is ignored.
        do_reset();
        commit_cnt = 8'b01_01_01_01;
        run_until(3);
        trap_valid[1] = 1'b1; trap_code[63:32] = 32'd1; trap_pc[127:64] = 64'h2222;
        run_until(5);
        #1;
        check("s3_done_c5", 64'(done), 64'd1);
        run_until(6);
        trap_valid[0] = 1'b1; trap_code[31:0] = 32'd0;
        run_until(10);
        check("s3_h0_still_pending", 64'(trap_valid[0]), 64'd1);
        check("s3_reports", 64'(log_q.size()), 64'd1);
        check_rep("s3", 0, 4, 4'h1, 32'd1, 64'h2222, 64'd3, 64'd4);
        trap_valid = '0;

        // Watchdog: commits stop at cycle 20.
        do_reset();
        commit_cnt = 8'b01_01_01_01;
        run_until(20);
        commit_cnt = '0;
        run_until(27);
        #1;
        check("s4_no_report_c27", 64'(mon_valid), 64'd0);
        run_until(28);
        #1;
        check("s4_done_c28", 64'(done), 64'd0);
        run_until(29);
        #1;
        check("s4_done_c29", 64'(done), 64'd1);
        run_until(32);
        check_rep("s4", 0, 28, 4'hF, 32'hFFFF_FFFE, 64'd0, 64'd27, 64'd0);

        // Trap and watchdog in the same cycle: trap first, watchdog 2 later.
        do_reset();
        commit_cnt = 8'b01_01_01_01;
        run_until(20);
        commit_cnt = '0;
        run_until(27);
        trap_valid[2] = 1'b1; trap_code[95:64] = 32'd0; trap_pc[191:128] = 64'hABC;
        run_until(31);
        #1;
        check("s5_done_c31", 64'(done), 64'd1);
        run_until(33);
        check("s5_reports", 64'(log_q.size()), 64'd2);
        check_rep("s5_trap", 0, 28, 4'h2, 32'd0, 64'hABC, 64'd27, 64'd20);
        check_rep("s5_wd",   1, 30, 4'hF, 32'hFFFF_FFFE, 64'd0, 64'd29, 64'd0);

        // Reset during REPORT discards the capture; the hart can trap again.
        do_reset();
        commit_cnt = 8'b01_01_01_01;
        run_until(4);
        trap_valid[3] = 1'b1; trap_code[127:96] = 32'd0; trap_pc[255:192] = 64'h3333;
        run_until(5);
        #1;
        check("s6_report_c5", 64'(mon_valid), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        tcyc = 0;
        log_q.delete();
        #1;
        check("s6_mon_valid_after", 64'(mon_valid), 64'd0);
        check("s6_done_after", 64'(done), 64'd0);
        check("s6_mon_cycle_after", mon_cycle, 64'd0);
        check("s6_mon_hart_after", 64'(mon_hart), 64'd0);
        run_until(2);
        trap_valid[3] = 1'b1;
        run_until(6);
        check("s6_reports", 64'(log_q.size()), 64'd1);
        check_rep("s6", 0, 3, 4'h3, 32'd0, 64'h3333, 64'd2, 64'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trap_report_arbiter.md
# trap_report_arbiter

Collects good/bad-trap events from up to 8 simulated harts, shares the single simulation trap-report port between them, and sequences the end of simulation. It keeps the global cycle counter and per-hart committed-instruction counters, grants one trap per report slot in round-robin order, and synthesises a timeout trap when every hart stops committing. It sits between the hart trap/commit signals and the simulation monitor, and drives that monitor's trap-valid, code, PC, cycle and instruction inputs.

## Interface
- NUM_HARTS, 2: number of harts, 1..8.
- TIMEOUT, 5000: consecutive zero-commit cycles before a timeout trap; 0 disables the watchdog.
- ABORT_ON_FAIL, 1: 1 = a non-zero trap code from any hart ends simulation immediately.

- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- trap_valid  in  NUM_HARTS  per-hart trap request; held until accepted.
- trap_code  in  32*NUM_HARTS  per-hart trap code; 0 = good trap.
- trap_pc  in  64*NUM_HARTS  per-hart trap PC.
- commit_cnt  in  2*NUM_HARTS  instructions committed by each hart this cycle, 0..3.
- trap_ready  out  NUM_HARTS  one-hot accept; a trap transfers when trap_valid[i] && trap_ready[i].
- mon_valid  out  1  one-cycle pulse: report fields are valid.
- mon_hart  out  4  reporting hart; 4'hF = watchdog.
- mon_code  out  32  trap code.
- mon_pc  out  64  trap PC.
- mon_cycle  out  64  cycle count at capture.
- mon_instr  out  64  reporting hart's instruction count at capture.
- done  out  1  simulation finished; sticky until reset.

## Operation
- States: RUN, REPORT, DONE. Reset state: RUN.
- Reset values: every output 0; cycle_cnt, all instr_cnt[i], wd_cnt and the trapped[] mask 0; round-robin pointer 0.
- cycle_cnt increments by 1 in every RUN and REPORT cycle, and freezes in DONE.
- instr_cnt[i] += commit_cnt[i] in every non-DONE cycle while trapped[i] = 0. The sum is 64-bit and wraps modulo 2^64.
- wd_cnt counts consecutive cycles in which all commit_cnt are 0. Any non-zero commit clears it to 0, and it saturates at TIMEOUT.
- **RUN arbitration**
  - Eligible harts: trap_valid[i] && !trapped[i].
  - The grant goes to the first eligible hart at or after the pointer, wrapping. trap_ready is one-hot on the grant and combinational from the current state and inputs.
  - trap_ready is never asserted to a trapped hart, or in REPORT or DONE.
- **On a handshake for hart g**
  - Capture hart g, its code and PC, the current cycle_cnt register value, and instr_cnt[g] including g's commits in that cycle.
  - Set trapped[g]; set the pointer to (g+1) mod NUM_HARTS; go to REPORT.
- **Watchdog** (TIMEOUT ≠ 0): in RUN with no handshake this cycle and wd_cnt == TIMEOUT, capture hart 4'hF, code 32'hFFFF_FFFE, PC 0, cycle_cnt, and instr 0; go to REPORT with the exit flag set. A trap handshake in the same cycle takes priority, and the watchdog is re-evaluated on the next RUN cycle.
- **REPORT** (exactly 1 cycle): mon_valid = 1 with the captured fields. The next state is DONE if any of the following hold; otherwise RUN:
  - all harts are trapped;
  - the exit flag is set;
  - ABORT_ON_FAIL = 1 and the captured code ≠ 0.
- **DONE**: done = 1, mon_valid = 0, and all counters hold. Only reset leaves DONE.
- The mon_* fields other than mon_valid hold their last captured value between reports.

## Timing
- Handshake in cycle T → mon_valid = 1 in cycle T+1 only. The earliest next handshake is T+2.
- done rises in the cycle after the final REPORT cycle.
- If commits stop from cycle c onward (commit in c-1, none from c), wd_cnt reaches TIMEOUT in cycle c+TIMEOUT-1. The watchdog fires then, mon_valid follows in c+TIMEOUT, and done rises in c+TIMEOUT+1.
- Simultaneous requests resolve in round-robin order, one report every 2 cycles.
- Reset asserted in any state, including mid-REPORT: the next cycle shows reset values, state RUN, and no mon_valid pulse. A capture in progress is discarded.

## Test plan
- **Single good trap.** NUM_HARTS=1; commit 1/cycle for 10 cycles after reset, then trap_valid with code 0, PC 0x8000_0100 at cycle 10.
  - ready in cycle 10; mon_valid in cycle 11 with cycle=10, instr=11, code=0.
  - done in cycle 12.
- **Round-robin.** NUM_HARTS=4; all trap_valid rise together with code 0.
  - Reports for harts 0, 1, 2, 3 on alternate cycles.
  - done after hart 3's report; a trapped hart's ready is never re-asserted.
- **Bad-trap abort.** Hart 1 traps with code 1 while hart 0 is still running, ABORT_ON_FAIL=1.
  - One report with hart 1, code 1; done next cycle.
  - Hart 0's later trap_valid is never accepted.
- **Watchdog.** TIMEOUT=8; commits stop at cycle 20.
  - mon_valid at cycle 28 with hart=F, code=FFFF_FFFE, cycle=27.
  - done at cycle 29.
- **Trap versus watchdog tie.** A handshake in the firing cycle.
  - The trap is reported first; the watchdog report follows 2 cycles later.
- **Reset mid-REPORT.**
  - done stays 0, mon_valid is 0, counters are 0 the next cycle, and the same hart can be accepted again.
